trace_recorder: RTL and testbench
=================================

# trace_recorder

Write-side counterpart of the trace-playback path: accepts a stream of 16-bit trace records over a valid/ready handshake and writes them at consecutive addresses into a single-port block RAM write port, starting at address 0. It is used to capture cache-simulator traffic (or generated traces) into the same BRAM image format that the playback reader walks sequentially. An optional end-of-trace marker word is appended when recording stops.

## Interface
- DATA_W, 16, record and BRAM data width
- ADDR_W, 16, BRAM address width
- DEPTH, 65536, usable BRAM words (must be ≤ 2**ADDR_W and ≥ 2)
- END_MARKER_EN, 1, append END_MARKER word on stop
- clk1  in  1  sole clock; all logic on rising edge
- rst  in  1  reset, synchronous and active-high
- start  in  1  pulse: arm recording from address 0 (ignored unless IDLE or DONE)
- stop  in  1  pulse: end recording (ignored unless RECORD)
- in_valid  in  1  record present on in_data
- in_data  in  DATA_W  trace record
- in_ready  out  1  recorder can accept a record this cycle
- mem_we  out  1  BRAM write enable (registered)
- mem_addr  out  ADDR_W  BRAM address (registered)
- mem_din  out  DATA_W  BRAM write data (registered)
- count  out  ADDR_W+1  records written this session (marker excluded)
- full  out  1  capacity exhausted
- busy  out  1  state is RECORD or MARK
- done  out  1  session finished, BRAM image complete

## Operation
- States: IDLE, RECORD, MARK, DONE.
- IDLE: in_ready=0. start → RECORD, write pointer wp=0, count=0, full=0.
- RECORD: in_ready = !full. Accept = in_valid && in_ready; on accept register mem_we=1, mem_addr=wp, mem_din=in_data; wp+1, count+1.
- Capacity: with END_MARKER_EN=1, record capacity is DEPTH-1 (one word reserved for marker); else DEPTH. full asserts when count reaches capacity; auto-transition to MARK (END_MARKER_EN=1) or DONE.
- stop in RECORD → MARK (END_MARKER_EN=1) or DONE. If stop and an accept occur in the same cycle, the record is written first; marker follows at next address.
- MARK: one cycle; register mem_we=1, mem_addr=wp, mem_din=END_MARKER; → DONE. in_ready=0.
- DONE: in_ready=0, done=1; count/full hold. start → RECORD (new session, count cleared). stop ignored.
- start while RECORD or MARK: ignored.
- wp never wraps; no write ever issued at address ≥ DEPTH.
- rst (any state, incl. mid-RECORD or MARK): next state IDLE; any write registered in the reset cycle is cancelled (mem_we=0).

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_din=0, count=0, full=0, busy=0, done=0.
- in_ready is combinational from state and full only (never from in_valid).
- Accept at edge N → mem_we/mem_addr/mem_din valid during cycle N+1; BRAM captures at edge N+1. count updates at edge N.
- mem_we deasserts the cycle after any non-accept cycle; back-to-back accepts give one write per cycle.
- start at edge N → in_ready=1 from cycle N+1.
- Last accept filling capacity at edge N: full=1 and in_ready=0 from cycle N+1; marker write registered at edge N+1; done=1 from cycle N+2.
- stop at edge N (no accept) → marker write during cycle N+1 driven at edge N+1... i.e. MARK at N+1, done=1 from N+2; without marker, done=1 from N+1.

## Structure
- Shared package: state enum (IDLE/RECORD/MARK/DONE), END_MARKER constant = 16'hFFFF, default DATA_W/ADDR_W.
- Single module; BRAM instantiated outside (by integrator, same IP family as playback memory). No sub-module required.

## Test plan
- Reset then start, 5 records 0x0010..0x0014 back-to-back, stop → writes at addr 0..4 with those data, marker 0xFFFF at addr 5, count=5, done=1.
- in_valid toggling every other cycle for 4 records → exactly 4 writes, consecutive addresses 0..3, no duplicate or skipped address.
- DEPTH=8, END_MARKER_EN=1, continuous in_valid → 7 records addr 0..6, full=1, in_ready=0, marker at addr 7, nothing at ≥8.
- stop coincident with accept of 0x0ABC as 3rd record → 0x0ABC at addr 2, marker at addr 3.
- rst asserted in cycle after an accept → no write that cycle, all outputs at reset values next cycle, start again writes from addr 0.
- start pulsed during RECORD and stop pulsed in IDLE/DONE → no state, count, or address change.

Source files
------------

// File: rtl/trace_recorder_pkg.sv
// Shared types and constants for the trace recorder: the session state enum
// and the end-of-trace marker word that the playback reader stops on.
package trace_recorder_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  localparam logic [15:0] END_MARKER = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    MARK,
    DONE
  } rec_state_e;

endpackage

// File: rtl/trace_recorder_if.sv
// Record stream, session control/status and BRAM write port of the trace recorder.
interface trace_recorder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              start;
  logic              stop;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_din, count, full, busy, done
  );

  modport slave (
    input  start, stop, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_din, count, full, busy, done
  );

endinterface

// File: rtl/trace_recorder.sv
// Captures a valid/ready stream of trace records into consecutive BRAM words
// from address 0, optionally terminating the image with an end marker word.
module trace_recorder
  import trace_recorder_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DEPTH         = 65536,
  parameter bit END_MARKER_EN = 1'b1
) (
  input logic             clk1,
  input logic             rst,
  trace_recorder_if.slave bus
);

  // One BRAM word is held back for the marker when it is enabled.
  localparam int              CAP_INT = END_MARKER_EN ? DEPTH - 1 : DEPTH;
  localparam logic [ADDR_W:0] CAP     = CAP_INT[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  rec_state_e        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              in_ready;
  logic              accept;

  assign in_ready = (state_q == RECORD) && !full_q;
  assign accept   = bus.in_valid && in_ready;

  // The record count doubles as the write pointer: the marker is never counted.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    full_d  = full_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RECORD;
          count_d = '0;
          full_d  = 1'b0;
        end
      end
      RECORD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          din_d   = bus.in_data;
          count_d = count_q + ONE;
        end
        full_d = (count_d == CAP);
        if (bus.stop || full_d) begin
          state_d = END_MARKER_EN ? MARK : DONE;
        end
      end
      MARK: begin
        we_d    = 1'b1;
        addr_d  = count_q[ADDR_W-1:0];
        din_d   = DATA_W'(END_MARKER);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= full_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.count    = count_q;
  assign bus.full     = full_q;
  assign bus.busy     = (state_q == RECORD) || (state_q == MARK);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_trace_recorder.sv
// Drives three recorder configurations with a shared stimulus stream and checks
// them every cycle against a session-level model, plus literal BRAM-image checks.
module tb_trace_recorder;

  localparam int P_IDLE = 0;
  localparam int P_REC  = 1;
  localparam int P_MARK = 2;
  localparam int P_DONE = 3;

  logic        clk1 = 1'b0;
  logic        rstS = 1'b1;
  logic        startS = 1'b0;
  logic        stopS = 1'b0;
  logic        validS = 1'b0;
  logic [15:0] dataS = 16'h0;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  int ph [3];
  int cnt [3];
  int cap [3];
  bit mk [3];
  bit mWe [3];
  int mAddr [3];
  int mDin [3];

  logic [15:0] capMem [int];
  int wrCnt [3];

  always #5 clk1 = ~clk1;

  trace_recorder_if #(.DATA_W(16), .ADDR_W(16)) busA ();
  trace_recorder_if #(.DATA_W(16), .ADDR_W(16)) busB ();
  trace_recorder_if #(.DATA_W(16), .ADDR_W(3))  busC ();

  assign busA.start = startS;  assign busA.stop = stopS;
  assign busA.in_valid = validS;  assign busA.in_data = dataS;
  assign busB.start = startS;  assign busB.stop = stopS;
  assign busB.in_valid = validS;  assign busB.in_data = dataS;
  assign busC.start = startS;  assign busC.stop = stopS;
  assign busC.in_valid = validS;  assign busC.in_data = dataS;

  trace_recorder #(.DATA_W(16), .ADDR_W(16), .DEPTH(65536), .END_MARKER_EN(1'b1))
    dutA (.clk1(clk1), .rst(rstS), .bus(busA));
  trace_recorder #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .END_MARKER_EN(1'b1))
    dutB (.clk1(clk1), .rst(rstS), .bus(busB));
  trace_recorder #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .END_MARKER_EN(1'b0))
    dutC (.clk1(clk1), .rst(rstS), .bus(busC));

  // Session-level model: records written so far equal the next write address.
  task automatic modelStep(input int i);
    if (rstS) begin
      ph[i] = P_IDLE; cnt[i] = 0; mWe[i] = 1'b0; mAddr[i] = 0; mDin[i] = 0;
      return;
    end
    mWe[i] = 1'b0;
    case (ph[i])
      P_IDLE, P_DONE: begin
        if (startS) begin ph[i] = P_REC; cnt[i] = 0; end
      end
      P_REC: begin
        if (validS && cnt[i] < cap[i]) begin
          mWe[i] = 1'b1; mAddr[i] = cnt[i]; mDin[i] = int'(dataS); cnt[i]++;
        end
        if (stopS || cnt[i] == cap[i]) ph[i] = mk[i] ? P_MARK : P_DONE;
      end
      P_MARK: begin
        mWe[i] = 1'b1; mAddr[i] = cnt[i]; mDin[i] = 32'hFFFF; ph[i] = P_DONE;
      end
      default: ph[i] = P_IDLE;
    endcase
  endtask

  always @(posedge clk1) begin
    for (int i = 0; i < 3; i++) modelStep(i);
    started <= 1'b1;
  end

  task automatic checkOutput(input int i, input logic rdy, input logic we,
                             input logic [15:0] addr, input logic [15:0] din,
                             input logic [16:0] cn, input logic fl,
                             input logic bz, input logic dn);
    logic eRdy, eFull, eBusy, eDone, bad;
    eRdy  = (ph[i] == P_REC) && (cnt[i] < cap[i]);
    eFull = (cnt[i] == cap[i]);
    eBusy = (ph[i] == P_REC) || (ph[i] == P_MARK);
    eDone = (ph[i] == P_DONE);
    bad = (rdy !== eRdy) || (we !== mWe[i]) || (cn !== 17'(cnt[i])) ||
          (fl !== eFull) || (bz !== eBusy) || (dn !== eDone);
    if (mWe[i] && ((addr !== 16'(mAddr[i])) || (din !== 16'(mDin[i])))) bad = 1'b1;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL cycle dut%0d t=%0t: got rdy=%b we=%b addr=%h din=%h cnt=%0d full=%b busy=%b done=%b; exp rdy=%b we=%b addr=%h din=%h cnt=%0d full=%b busy=%b done=%b",
               i, $time, rdy, we, addr, din, cn, fl, bz, dn,
               eRdy, mWe[i], 16'(mAddr[i]), 16'(mDin[i]), cnt[i], eFull, eBusy, eDone);
    end
  endtask

  // Compare on the falling edge and log every BRAM write into an image.
  always @(negedge clk1) begin
    if (started) begin
      checkOutput(0, busA.in_ready, busA.mem_we, busA.mem_addr, busA.mem_din,
                  busA.count, busA.full, busA.busy, busA.done);
      checkOutput(1, busB.in_ready, busB.mem_we, busB.mem_addr, busB.mem_din,
                  busB.count, busB.full, busB.busy, busB.done);
      checkOutput(2, busC.in_ready, busC.mem_we, 16'(busC.mem_addr), busC.mem_din,
                  17'(busC.count), busC.full, busC.busy, busC.done);
      if (busA.mem_we === 1'b1) begin capMem[int'(busA.mem_addr)] = busA.mem_din; wrCnt[0]++; end
      if (busB.mem_we === 1'b1) begin capMem[100000 + int'(busB.mem_addr)] = busB.mem_din; wrCnt[1]++; end
      if (busC.mem_we === 1'b1) begin capMem[200000 + int'(busC.mem_addr)] = busC.mem_din; wrCnt[2]++; end
    end
  end

  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic v, input logic [15:0] d);
    rstS = r; startS = s; stopS = p; validS = v; dataS = d;
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic clearCaps();
    capMem.delete();
    for (int i = 0; i < 3; i++) wrCnt[i] = 0;
  endtask

  task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, exp %0h", nm, act, exp);
    end
  endtask

  task automatic checkCap(input string nm, input int key, input logic [15:0] exp);
    logic [31:0] act;
    act = capMem.exists(key) ? {16'h0, capMem[key]} : 32'hFFFF_FFFF;
    checkVal(nm, act, {16'h0, exp});
  endtask

  initial begin
    logic [15:0] saved [4];
    int nSaved;
    int highKeys;

    cap = '{65535, 7, 8};
    mk  = '{1'b1, 1'b1, 1'b0};

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    checkVal("reset in_ready", 32'(busA.in_ready), 0);
    checkVal("reset mem_addr", 32'(busA.mem_addr), 0);
    checkVal("reset mem_din", 32'(busA.mem_din), 0);
    checkVal("reset count", 32'(busA.count), 0);
    stopS = 1'b1;
    idle(1);
    checkVal("stop in idle busy", 32'(busA.busy), 0);

    // Five back-to-back records then stop.
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010 + 16'(i));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);
    for (int i = 0; i < 5; i++) checkCap("burst data", i, 16'h0010 + 16'(i));
    checkCap("burst marker", 5, 16'hFFFF);
    checkVal("burst count", 32'(busA.count), 5);
    checkVal("burst done", 32'(busA.done), 1);
    checkVal("burst writes", 32'(wrCnt[0]), 6);
    checkVal("no-marker writes", 32'(wrCnt[2]), 5);

    // in_valid toggling every other cycle.
    clearCaps();
    nSaved = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        saved[nSaved] = 16'($urandom_range(0, 16'hFFFE));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, saved[nSaved]);
        nSaved++;
      end else begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);
    for (int i = 0; i < 4; i++) checkCap("toggle data", i, saved[i]);
    checkCap("toggle marker", 4, 16'hFFFF);
    checkVal("toggle writes", 32'(wrCnt[0]), 5);

    // Continuous stream: the small instances hit capacity.
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0100 + 16'(i));
    checkVal("cap full", 32'(busB.full), 1);
    checkVal("cap in_ready", 32'(busB.in_ready), 0);
    checkVal("cap count", 32'(busB.count), 7);
    checkVal("cap done", 32'(busB.done), 1);
    checkCap("cap last record", 100006, 16'h0106);
    checkCap("cap marker", 100007, 16'hFFFF);
    checkVal("cap writes", 32'(wrCnt[1]), 8);
    highKeys = 0;
    foreach (capMem[k]) if (k >= 100008 && k < 200000) highKeys++;
    checkVal("cap beyond depth", 32'(highKeys), 0);
    checkVal("nomark count", 32'(busC.count), 8);
    checkVal("nomark full", 32'(busC.full), 1);
    checkVal("nomark writes", 32'(wrCnt[2]), 8);
    checkCap("nomark last", 200007, 16'h0107);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);

    // stop coincident with the third accept.
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0002);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h0ABC);
    idle(3);
    checkCap("stop+accept data", 2, 16'h0ABC);
    checkCap("stop+accept marker", 3, 16'hFFFF);
    checkVal("stop+accept count", 32'(busA.count), 3);

    // Reset right after an accept cancels the following write.
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h9999);
    checkVal("rst mem_we", 32'(busA.mem_we), 0);
    checkVal("rst mem_addr", 32'(busA.mem_addr), 0);
    checkVal("rst mem_din", 32'(busA.mem_din), 0);
    checkVal("rst count", 32'(busA.count), 0);
    idle(2);
    checkVal("rst writes", 32'(wrCnt[0]), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h55AA);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);
    checkCap("restart addr0", 0, 16'h55AA);
    checkVal("restart writes", 32'(wrCnt[0]), 3);

    // stop in DONE and start during RECORD are ignored.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    checkVal("stop in done", 32'(busA.done), 1);
    checkVal("stop in done count", 32'(busA.count), 1);
    clearCaps();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0021);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0022);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    checkVal("start in record count", 32'(busA.count), 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0023);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    idle(3);
    checkCap("start in record addr", 2, 16'h0023);
    checkVal("start in record final", 32'(busA.count), 3);

    // Randomized traffic checked by the per-cycle model.
    for (int n = 0; n < 2000; n++) begin
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
                    16'($urandom));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
